// File: rtl/game_pkg.sv
// Shared 2048 definitions: state/direction encodings, board geometry and the
// combinational move units used by the controller and the AI search block.
package game_pkg;

  localparam int unsigned CELL_W   = 4;
  localparam int unsigned N_CELLS  = 16;
  localparam int unsigned BOARD_W  = CELL_W * N_CELLS;
  localparam logic [3:0]  TILE_WIN = 4'd11;

  typedef enum logic [2:0] {
    ST_INPUT  = 3'b000,
    ST_MERGE  = 3'b001,
    ST_GEN    = 3'b010,
    ST_CHECK  = 3'b011,
    ST_END    = 3'b100,
    ST_SEARCH = 3'b101
  } state_t;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_t;

  function automatic logic dir_valid(input logic [2:0] d);
    return (d != DIR_NONE) && (d <= DIR_RIGHT);
  endfunction

  // Row 0 / col 0 is the top-left cell, held in the most significant nibble.
  function automatic int unsigned cell_idx(input int unsigned row, input int unsigned col);
    return (N_CELLS - 1) - (4 * row + col);
  endfunction

  function automatic logic [3:0] cell_at(input logic [BOARD_W-1:0] b,
                                         input int unsigned row, input int unsigned col);
    return b[CELL_W * cell_idx(row, col) +: CELL_W];
  endfunction

  // Element m of line k, where m = 0 is the edge the tiles slide towards.
  function automatic int unsigned line_cell(input logic [2:0] d, input int unsigned k,
                                            input int unsigned m);
    int unsigned r;
    int unsigned c;
    case (d)
      DIR_UP:    begin r = m;     c = k;     end
      DIR_DOWN:  begin r = 3 - m; c = k;     end
      DIR_RIGHT: begin r = k;     c = 3 - m; end
      default:   begin r = k;     c = m;     end
    endcase
    return cell_idx(r, c);
  endfunction

  // Compact towards element 0, then merge each equal pair at most once.
  function automatic logic [15:0] slide_line(input logic [15:0] line);
    logic [19:0]  tmp;
    logic [15:0]  res;
    int unsigned  n;
    logic         skip;
    tmp = '0;
    n   = 0;
    for (int unsigned m = 0; m < 4; m++) begin
      if (line[CELL_W*m +: CELL_W] != '0) begin
        tmp[CELL_W*n +: CELL_W] = line[CELL_W*m +: CELL_W];
        n++;
      end
    end
    res  = '0;
    n    = 0;
    skip = 1'b0;
    for (int unsigned m = 0; m < 4; m++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (tmp[CELL_W*m +: CELL_W] != '0) begin
        if (tmp[CELL_W*m +: CELL_W] == tmp[CELL_W*(m+1) +: CELL_W]) begin
          res[CELL_W*n +: CELL_W] = tmp[CELL_W*m +: CELL_W] + 4'd1;
          skip = 1'b1;
        end else begin
          res[CELL_W*n +: CELL_W] = tmp[CELL_W*m +: CELL_W];
        end
        n++;
      end
    end
    return res;
  endfunction

  function automatic logic [BOARD_W-1:0] move_board(input logic [BOARD_W-1:0] b,
                                                    input logic [2:0] d);
    logic [BOARD_W-1:0] res;
    logic [15:0]        line;
    res = b;
    if (dir_valid(d)) begin
      for (int unsigned k = 0; k < 4; k++) begin
        line = '0;
        for (int unsigned m = 0; m < 4; m++)
          line[CELL_W*m +: CELL_W] = b[CELL_W * line_cell(d, k, m) +: CELL_W];
        line = slide_line(line);
        for (int unsigned m = 0; m < 4; m++)
          res[CELL_W * line_cell(d, k, m) +: CELL_W] = line[CELL_W*m +: CELL_W];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/game_ctrl_tile_spawner.sv
// Free-running spawn LFSR and a wrap-around scan that places one new tile in
// the first empty cell at or after the LFSR-selected start index.
module tile_spawner
  import game_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BOARD_W-1:0] board,
  output logic [BOARD_W-1:0] spawned,
  output logic               empty_found
);

  logic [15:0] lfsr;
  logic        feedback;
  logic [3:0]  spawn_val;
  logic [3:0]  scan_idx;

  assign feedback  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign spawn_val = (lfsr[7:4] == 4'd0) ? 4'd2 : 4'd1;

  always_ff @(posedge clk) begin
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= {lfsr[14:0], feedback};
  end

  always_comb begin
    spawned     = board;
    empty_found = 1'b0;
    scan_idx    = '0;
    for (int unsigned k = 0; k < N_CELLS; k++) begin
      scan_idx = lfsr[3:0] + 4'(k);
      if (!empty_found && board[CELL_W*scan_idx +: CELL_W] == '0) begin
        spawned[CELL_W*scan_idx +: CELL_W] = spawn_val;
        empty_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// 2048 game controller: board state, manual/AI direction intake, move, spawn,
// and win/loss detection. The state output is the handshake to the AI block.
module game_ctrl
  import game_pkg::*;
#(
  parameter logic [63:0] INIT_BOARD = 64'h0000_0000_0010_0001,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   dir_in,
  input  logic         ai_mode,
  input  logic [2:0]   ai_dir,
  output logic [2:0]   state,
  output logic [63:0]  board,
  output logic [15:0]  move_count,
  output logic         won,
  output logic         over
);

  state_t             state_q, state_d;
  logic [BOARD_W-1:0] board_q, board_d;
  logic [15:0]        mc_q, mc_d;
  logic               won_q, won_d;
  logic               over_q, over_d;
  logic               armed_q, armed_d;
  logic [2:0]         dir_q, dir_d;
  logic [BOARD_W-1:0] moved;
  logic [BOARD_W-1:0] spawned;
  logic               empty_found;

  function automatic logic has_win(input logic [BOARD_W-1:0] b);
    logic hit;
    hit = 1'b0;
    for (int unsigned i = 0; i < N_CELLS; i++)
      if (b[CELL_W*i +: CELL_W] == TILE_WIN) hit = 1'b1;
    return hit;
  endfunction

  // Dead when full and no orthogonal neighbour pair could merge.
  function automatic logic board_dead(input logic [BOARD_W-1:0] b);
    logic dead;
    dead = 1'b1;
    for (int unsigned r = 0; r < 4; r++) begin
      for (int unsigned c = 0; c < 4; c++) begin
        if (cell_at(b, r, c) == '0) dead = 1'b0;
        if (c < 3 && cell_at(b, r, c) == cell_at(b, r, c + 1)) dead = 1'b0;
        if (r < 3 && cell_at(b, r, c) == cell_at(b, r + 1, c)) dead = 1'b0;
      end
    end
    return dead;
  endfunction

  assign moved = move_board(board_q, dir_q);

  tile_spawner #(
    .LFSR_SEED (LFSR_SEED)
  ) u_spawner (
    .clk         (clk),
    .rst         (rst),
    .board       (board_q),
    .spawned     (spawned),
    .empty_found (empty_found)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INPUT;
      board_q <= INIT_BOARD;
      mc_q    <= '0;
      won_q   <= 1'b0;
      over_q  <= 1'b0;
      armed_q <= 1'b1;
      dir_q   <= '0;
    end else begin
      state_q <= state_d;
      board_q <= board_d;
      mc_q    <= mc_d;
      won_q   <= won_d;
      over_q  <= over_d;
      armed_q <= armed_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    board_d = board_q;
    mc_d    = mc_q;
    won_d   = won_q;
    over_d  = over_q;
    armed_d = armed_q;
    dir_d   = dir_q;
    // Re-arm on any released cycle so a held button yields exactly one move.
    if (!dir_valid(dir_in)) armed_d = 1'b1;
    case (state_q)
      ST_INPUT: begin
        if (ai_mode) begin
          state_d = ST_SEARCH;
        end else if (armed_q && dir_valid(dir_in)) begin
          dir_d   = dir_in;
          armed_d = 1'b0;
          state_d = ST_MERGE;
        end
      end
      ST_SEARCH: begin
        if (!ai_mode) begin
          state_d = ST_INPUT;
        end else if (dir_valid(ai_dir)) begin
          dir_d   = ai_dir;
          state_d = ST_MERGE;
        end
      end
      ST_MERGE: begin
        if (moved != board_q) begin
          board_d = moved;
          mc_d    = (mc_q == '1) ? mc_q : mc_q + 16'd1;
          state_d = ST_GEN;
        end else begin
          state_d = ST_CHECK;
        end
      end
      ST_GEN: begin
        if (empty_found) board_d = spawned;
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (has_win(board_q)) begin
          won_d   = 1'b1;
          state_d = ST_END;
        end else if (board_dead(board_q)) begin
          over_d  = 1'b1;
          state_d = ST_END;
        end else begin
          state_d = ST_INPUT;
        end
      end
      ST_END:  state_d = ST_END;
      default: state_d = ST_INPUT;
    endcase
    if (state_d == ST_INPUT) dir_d = '0;
  end

  assign state      = state_q;
  assign board      = board_q;
  assign move_count = mc_q;
  assign won        = won_q;
  assign over       = over_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: five instances with different start boards
// share clk/rst; expected per-cycle snapshots are queued when stimulus is driven.
module tb_game_ctrl;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [63:0] INITS [5] = '{
    64'h0000_0000_0010_0001,
    64'h1000_0000_0000_0000,
    64'h1100_0000_0000_0000,
    64'hAA00_0000_0000_0000,
    64'h1212_2121_1212_2121
  };

  typedef struct packed {
    logic [2:0]  st;
    logic [63:0] bd;
    logic        chk_bd;
    logic [15:0] mc;
    logic        won;
    logic        over;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  dir_in  [5];
  logic        ai_mode [5];
  logic [2:0]  ai_dir  [5];
  logic [2:0]  st_o    [5];
  logic [63:0] bd_o    [5];
  logic [15:0] mc_o    [5];
  logic        won_o   [5];
  logic        over_o  [5];
  logic [15:0] m_lfsr;

  exp_t q[$];
  exp_t e;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  game_ctrl u_dut0 (
    .clk(clk), .rst(rst), .dir_in(dir_in[0]), .ai_mode(ai_mode[0]), .ai_dir(ai_dir[0]),
    .state(st_o[0]), .board(bd_o[0]), .move_count(mc_o[0]), .won(won_o[0]), .over(over_o[0])
  );

  for (genvar g = 1; g < 5; g++) begin : g_dut
    game_ctrl #(.INIT_BOARD(INITS[g]), .LFSR_SEED(SEED)) u_dut (
      .clk(clk), .rst(rst), .dir_in(dir_in[g]), .ai_mode(ai_mode[g]), .ai_dir(ai_dir[g]),
      .state(st_o[g]), .board(bd_o[g]), .move_count(mc_o[g]), .won(won_o[g]), .over(over_o[g])
    );
  end

  function automatic logic [15:0] adv1(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic logic [15:0] adv(input logic [15:0] v, input int n);
    logic [15:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = adv1(r);
    return r;
  endfunction

  function automatic logic [63:0] spawn(input logic [63:0] b, input logic [15:0] l);
    logic [63:0] r;
    logic [3:0]  idx;
    logic        done;
    r    = b;
    done = 1'b0;
    for (int k = 0; k < 16; k++) begin
      idx = l[3:0] + 4'(k);
      if (!done && r[4*idx +: 4] == 4'd0) begin
        r[4*idx +: 4] = (l[7:4] == 4'd0) ? 4'd2 : 4'd1;
        done = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic exp_t mk(input logic [2:0] st, input logic [63:0] bd, input logic chk,
                              input logic [15:0] mc, input logic w, input logic o);
    exp_t x;
    x.st = st; x.bd = bd; x.chk_bd = chk; x.mc = mc; x.won = w; x.over = o;
    return x;
  endfunction

  always @(posedge clk) m_lfsr <= rst ? SEED : adv1(m_lfsr);

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      dir_in[k] = 3'd0; ai_mode[k] = 1'b0; ai_dir[k] = 3'd0;
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 5; k++) q.push_back(mk(3'd0, INITS[k], 1'b1, 16'd0, 1'b0, 1'b0));
    for (int k = 0; k < 5; k++) begin
      e = q.pop_front();
      n_chk++;
      if (st_o[k] !== e.st || bd_o[k] !== e.bd || mc_o[k] !== e.mc ||
          won_o[k] !== e.won || over_o[k] !== e.over) begin
        n_fail++;
        $display("FAIL reset[%0d]: got st=%0d bd=%h mc=%0d won=%b over=%b, want st=%0d bd=%h mc=%0d won=%b over=%b",
                 k, st_o[k], bd_o[k], mc_o[k], won_o[k], over_o[k], e.st, e.bd, e.mc, e.won, e.over);
      end
    end
  endtask

  task automatic test_no_move();
    do_reset();
    dir_in[1] = 3'd1;
    q.push_back(mk(3'd1, INITS[1], 1'b1, 16'd0, 1'b0, 1'b0));
    q.push_back(mk(3'd3, INITS[1], 1'b1, 16'd0, 1'b0, 1'b0));
    q.push_back(mk(3'd0, INITS[1], 1'b1, 16'd0, 1'b0, 1'b0));
    for (int i = 0; q.size() > 0; i++) begin
      @(negedge clk);
      e = q.pop_front();
      n_chk++;
      if (st_o[1] !== e.st || bd_o[1] !== e.bd || mc_o[1] !== e.mc ||
          won_o[1] !== e.won || over_o[1] !== e.over) begin
        n_fail++;
        $display("FAIL no_move[%0d]: got st=%0d bd=%h mc=%0d, want st=%0d bd=%h mc=%0d",
                 i, st_o[1], bd_o[1], mc_o[1], e.st, e.bd, e.mc);
      end
      if (i == 0) dir_in[1] = 3'd0;
    end
  endtask

  task automatic test_move();
    logic [63:0] mv, sp;
    do_reset();
    mv = 64'h2000_0000_0000_0000;
    sp = spawn(mv, adv(m_lfsr, 2));
    dir_in[2] = 3'd3;
    q.push_back(mk(3'd1, INITS[2], 1'b1, 16'd0, 1'b0, 1'b0));
    q.push_back(mk(3'd2, mv, 1'b1, 16'd1, 1'b0, 1'b0));
    q.push_back(mk(3'd3, sp, 1'b1, 16'd1, 1'b0, 1'b0));
    q.push_back(mk(3'd0, sp, 1'b1, 16'd1, 1'b0, 1'b0));
    for (int i = 0; q.size() > 0; i++) begin
      @(negedge clk);
      e = q.pop_front();
      n_chk++;
      if (st_o[2] !== e.st || bd_o[2] !== e.bd || mc_o[2] !== e.mc ||
          won_o[2] !== e.won || over_o[2] !== e.over) begin
        n_fail++;
        $display("FAIL move[%0d]: got st=%0d bd=%h mc=%0d, want st=%0d bd=%h mc=%0d",
                 i, st_o[2], bd_o[2], mc_o[2], e.st, e.bd, e.mc);
      end
      if (i == 0) dir_in[2] = 3'd0;
    end
  endtask

  task automatic test_held();
    logic [63:0] mv, sp;
    do_reset();
    mv = 64'h2000_0000_0000_0000;
    sp = spawn(mv, adv(m_lfsr, 2));
    dir_in[2] = 3'd3;
    q.push_back(mk(3'd1, INITS[2], 1'b1, 16'd0, 1'b0, 1'b0));
    q.push_back(mk(3'd2, mv, 1'b1, 16'd1, 1'b0, 1'b0));
    q.push_back(mk(3'd3, sp, 1'b1, 16'd1, 1'b0, 1'b0));
    for (int i = 3; i < 21; i++) q.push_back(mk(3'd0, sp, 1'b1, 16'd1, 1'b0, 1'b0));
    q.push_back(mk(3'd1, sp, 1'b1, 16'd1, 1'b0, 1'b0));
    q.push_back(mk(3'd2, sp, 1'b0, 16'd2, 1'b0, 1'b0));
    q.push_back(mk(3'd3, sp, 1'b0, 16'd2, 1'b0, 1'b0));
    q.push_back(mk(3'd0, sp, 1'b0, 16'd2, 1'b0, 1'b0));
    for (int i = 0; q.size() > 0; i++) begin
      @(negedge clk);
      e = q.pop_front();
      n_chk++;
      if (st_o[2] !== e.st || (e.chk_bd && bd_o[2] !== e.bd) || mc_o[2] !== e.mc ||
          won_o[2] !== e.won || over_o[2] !== e.over) begin
        n_fail++;
        $display("FAIL held[%0d]: got st=%0d bd=%h mc=%0d, want st=%0d bd=%h mc=%0d",
                 i, st_o[2], bd_o[2], mc_o[2], e.st, e.bd, e.mc);
      end
      if (i == 19) dir_in[2] = 3'd0;
      if (i == 20) dir_in[2] = 3'd4;
      if (i == 21) dir_in[2] = 3'd0;
    end
    n_chk++;
    if (bd_o[2] === sp) begin
      n_fail++;
      $display("FAIL held_right_board: got %h, want a board different from %h", bd_o[2], sp);
    end
  endtask

  task automatic test_win();
    logic [63:0] mv, sp;
    do_reset();
    mv = 64'hB000_0000_0000_0000;
    sp = spawn(mv, adv(m_lfsr, 2));
    dir_in[3] = 3'd3;
    q.push_back(mk(3'd1, INITS[3], 1'b1, 16'd0, 1'b0, 1'b0));
    q.push_back(mk(3'd2, mv, 1'b1, 16'd1, 1'b0, 1'b0));
    q.push_back(mk(3'd3, sp, 1'b1, 16'd1, 1'b0, 1'b0));
    for (int i = 3; i < 10; i++) q.push_back(mk(3'd4, sp, 1'b1, 16'd1, 1'b1, 1'b0));
    for (int i = 0; q.size() > 0; i++) begin
      @(negedge clk);
      e = q.pop_front();
      n_chk++;
      if (st_o[3] !== e.st || bd_o[3] !== e.bd || mc_o[3] !== e.mc ||
          won_o[3] !== e.won || over_o[3] !== e.over) begin
        n_fail++;
        $display("FAIL win[%0d]: got st=%0d bd=%h mc=%0d won=%b over=%b, want st=%0d bd=%h mc=%0d won=%b over=%b",
                 i, st_o[3], bd_o[3], mc_o[3], won_o[3], over_o[3], e.st, e.bd, e.mc, e.won, e.over);
      end
      dir_in[3]  = (i >= 3 && i % 2 == 1) ? 3'd4 : 3'd0;
      ai_mode[3] = (i >= 3);
      ai_dir[3]  = (i >= 3) ? 3'd2 : 3'd0;
    end
    do_reset();
    q.push_back(mk(3'd0, INITS[3], 1'b1, 16'd0, 1'b0, 1'b0));
    e = q.pop_front();
    n_chk++;
    if (st_o[3] !== e.st || bd_o[3] !== e.bd || mc_o[3] !== e.mc ||
        won_o[3] !== e.won || over_o[3] !== e.over) begin
      n_fail++;
      $display("FAIL win_reset: got st=%0d bd=%h mc=%0d won=%b, want st=%0d bd=%h mc=%0d won=%b",
               st_o[3], bd_o[3], mc_o[3], won_o[3], e.st, e.bd, e.mc, e.won);
    end
  endtask

  task automatic test_over();
    do_reset();
    dir_in[4] = 3'd4;
    q.push_back(mk(3'd1, INITS[4], 1'b1, 16'd0, 1'b0, 1'b0));
    q.push_back(mk(3'd3, INITS[4], 1'b1, 16'd0, 1'b0, 1'b0));
    for (int i = 2; i < 5; i++) q.push_back(mk(3'd4, INITS[4], 1'b1, 16'd0, 1'b0, 1'b1));
    for (int i = 0; q.size() > 0; i++) begin
      @(negedge clk);
      e = q.pop_front();
      n_chk++;
      if (st_o[4] !== e.st || bd_o[4] !== e.bd || mc_o[4] !== e.mc ||
          won_o[4] !== e.won || over_o[4] !== e.over) begin
        n_fail++;
        $display("FAIL over[%0d]: got st=%0d mc=%0d won=%b over=%b, want st=%0d mc=%0d won=%b over=%b",
                 i, st_o[4], mc_o[4], won_o[4], over_o[4], e.st, e.mc, e.won, e.over);
      end
      dir_in[4] = (i == 3) ? 3'd1 : 3'd0;
    end
  endtask

  task automatic test_ai();
    logic [63:0] mv, sp;
    do_reset();
    mv = 64'h0000_0000_0000_0011;
    sp = spawn(mv, adv(m_lfsr, 102));
    ai_mode[0] = 1'b1;
    dir_in[0]  = 3'd3;
    for (int i = 0; i < 100; i++) q.push_back(mk(3'd5, INITS[0], 1'b1, 16'd0, 1'b0, 1'b0));
    q.push_back(mk(3'd1, INITS[0], 1'b1, 16'd0, 1'b0, 1'b0));
    q.push_back(mk(3'd2, mv, 1'b1, 16'd1, 1'b0, 1'b0));
    q.push_back(mk(3'd3, sp, 1'b1, 16'd1, 1'b0, 1'b0));
    q.push_back(mk(3'd0, sp, 1'b1, 16'd1, 1'b0, 1'b0));
    q.push_back(mk(3'd5, sp, 1'b1, 16'd1, 1'b0, 1'b0));
    q.push_back(mk(3'd5, sp, 1'b1, 16'd1, 1'b0, 1'b0));
    q.push_back(mk(3'd0, sp, 1'b1, 16'd1, 1'b0, 1'b0));
    q.push_back(mk(3'd0, sp, 1'b1, 16'd1, 1'b0, 1'b0));
    for (int i = 0; q.size() > 0; i++) begin
      @(negedge clk);
      e = q.pop_front();
      n_chk++;
      if (st_o[0] !== e.st || bd_o[0] !== e.bd || mc_o[0] !== e.mc ||
          won_o[0] !== e.won || over_o[0] !== e.over) begin
        n_fail++;
        $display("FAIL ai[%0d]: got st=%0d bd=%h mc=%0d, want st=%0d bd=%h mc=%0d",
                 i, st_o[0], bd_o[0], mc_o[0], e.st, e.bd, e.mc);
      end
      if (i == 0)   dir_in[0]  = 3'd0;
      if (i == 99)  ai_dir[0]  = 3'd2;
      if (i == 100) ai_dir[0]  = 3'd0;
      if (i == 105) ai_mode[0] = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 5; k++) begin
      dir_in[k] = 3'd0; ai_mode[k] = 1'b0; ai_dir[k] = 3'd0;
    end
    test_reset();
    test_no_move();
    test_move();
    test_held();
    test_win();
    test_over();
    test_ai();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
